// File: rtl/cpu_ctrl_pkg.sv
// Shared encodings and defaults for the CPU step controller.
// State codes are visible on ctrlState, so keep them stable.
package cpu_ctrl_pkg;

  localparam int unsigned DB_CYCLES_DEF = 500000;
  localparam int unsigned RUN_DIV_DEF   = 5000000;
  localparam int unsigned RATE_W        = 24;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_RUN    = 2'b01,
    ST_HALTED = 2'b10
  } ctrl_state_e;

endpackage

// File: rtl/button_debounce.sv
// Two-flop synchronizer plus stable-count debouncer.
// The level flips only after DB_CYCLES consecutive differing samples.
module button_debounce
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic level
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          s1_q;
  logic          s2_q;
  logic          lvl_q;
  logic          lvl_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  always_comb begin
    lvl_d = lvl_q;
    cnt_d = '0;
    if (s2_q != lvl_q) begin
      if (cnt_q == CW'(DB_CYCLES - 1)) begin
        lvl_d = s2_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      lvl_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      s1_q  <= raw;
      s2_q  <= s1_q;
      lvl_q <= lvl_d;
      cnt_q <= cnt_d;
    end
  end

  assign level = lvl_q;

endmodule

// File: rtl/step_controller.sv
// Button-driven single-step / free-run controller for the CPU.
// Halt latches until reset; steps are registered one-cycle pulses.
module step_controller
  import cpu_ctrl_pkg::*;
#(
  parameter int unsigned DB_CYCLES = DB_CYCLES_DEF,
  parameter int unsigned RUN_DIV   = RUN_DIV_DEF,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pushButton,
  input  logic             runMode,
  input  logic             haltReq,
  output logic             cpuStep,
  output logic [1:0]       ctrlState,
  output logic [CNT_W-1:0] stepCount
);

  logic              push_lvl;
  logic              run_lvl;
  logic              push_prev_q;
  logic              press;
  ctrl_state_e       state_q;
  ctrl_state_e       state_d;
  logic [RATE_W-1:0] rate_q;
  logic [RATE_W-1:0] rate_d;
  logic              step_q;
  logic              step_d;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_push (
    .clk   (clk),
    .reset (reset),
    .raw   (pushButton),
    .level (push_lvl)
  );

  button_debounce #(.DB_CYCLES(DB_CYCLES)) u_mode (
    .clk   (clk),
    .reset (reset),
    .raw   (runMode),
    .level (run_lvl)
  );

  assign press = push_lvl & ~push_prev_q;

  // Priority: halt, then press, then mode change, then rate tick.
  always_comb begin
    state_d = state_q;
    rate_d  = '0;
    step_d  = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (haltReq) begin
          state_d = ST_HALTED;
        end else if (press) begin
          if (run_lvl) state_d = ST_RUN;
          else         step_d  = 1'b1;
        end
      end
      ST_RUN: begin
        if (haltReq) begin
          state_d = ST_HALTED;
        end else if (press || !run_lvl) begin
          state_d = ST_IDLE;
        end else if (rate_q == RATE_W'(RUN_DIV - 1)) begin
          step_d = 1'b1;
        end else begin
          rate_d = rate_q + RATE_W'(1);
        end
      end
      ST_HALTED: begin
        state_d = ST_HALTED;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
    cnt_d = cnt_q + CNT_W'(step_d);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      push_prev_q <= 1'b0;
      state_q     <= ST_IDLE;
      rate_q      <= '0;
      step_q      <= 1'b0;
      cnt_q       <= '0;
    end else begin
      push_prev_q <= push_lvl;
      state_q     <= state_d;
      rate_q      <= rate_d;
      step_q      <= step_d;
      cnt_q       <= cnt_d;
    end
  end

  assign cpuStep   = step_q;
  assign ctrlState = state_q;
  assign stepCount = cnt_q;

endmodule

// File: tb/tb_step_controller.sv
// Bench for step_controller: directed scenarios plus random traffic
// checked cycle by cycle against a behavioural reference model.
module tb_step_controller;

  localparam int DB  = 4;
  localparam int DIV = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        pushButton = 1'b0;
  logic        runMode = 1'b0;
  logic        haltReq = 1'b0;
  logic        step_a;
  logic [1:0]  state_a;
  logic [15:0] cnt_a;
  logic        step_b;
  logic [1:0]  state_b;
  logic [3:0]  cnt_b;

  int tests = 0;
  int fails = 0;

  step_controller #(.DB_CYCLES(DB), .RUN_DIV(DIV), .CNT_W(16)) dut (
    .clk(clk), .reset(reset), .pushButton(pushButton),
    .runMode(runMode), .haltReq(haltReq),
    .cpuStep(step_a), .ctrlState(state_a), .stepCount(cnt_a)
  );

  step_controller #(.DB_CYCLES(DB), .RUN_DIV(DIV), .CNT_W(4)) dut_w (
    .clk(clk), .reset(reset), .pushButton(pushButton),
    .runMode(runMode), .haltReq(haltReq),
    .cpuStep(step_b), .ctrlState(state_b), .stepCount(cnt_b)
  );

  always #5 clk = ~clk;

  // Reference model: mode 0 idle, 1 run, 2 halted
  bit ps1, ps2, rs1, rs2;
  bit qp[$];
  bit qr[$];
  bit m_pl, m_pl_prev, m_rl;
  int m_mode, m_age, m_cnt;
  bit m_step;

  int  tick_no = 0;
  int  steps_seen = 0;
  int  first_step = -1;
  bit  prev_step = 1'b0;

  task automatic chk(string tag, logic [31:0] obs,
                     logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s got %0h exp %0h", tag, obs, exp);
    end
  endtask

  function automatic bit settled(input bit q[$], input bit lvl);
    if (q.size() < DB) return 1'b0;
    foreach (q[i]) if (q[i] == lvl) return 1'b0;
    return 1'b1;
  endfunction

  function automatic logic [1:0] mode_code(input int m);
    if (m == 1) return 2'b01;
    if (m == 2) return 2'b10;
    return 2'b00;
  endfunction

  task automatic model_clear();
    ps1 = 0; ps2 = 0; rs1 = 0; rs2 = 0;
    qp.delete(); qr.delete();
    m_pl = 0; m_pl_prev = 0; m_rl = 0;
    m_mode = 0; m_age = 0; m_cnt = 0; m_step = 0;
  endtask

  task automatic model_edge();
    bit press;
    bit old_pl;
    if (!reset) begin
      model_clear();
      return;
    end
    press = m_pl && !m_pl_prev;
    m_step = 0;
    case (m_mode)
      0: begin
        if (haltReq) m_mode = 2;
        else if (press && m_rl) begin m_mode = 1; m_age = 0; end
        else if (press) m_step = 1;
      end
      1: begin
        if (haltReq) m_mode = 2;
        else if (press || !m_rl) m_mode = 0;
        else begin
          m_age++;
          if (m_age == DIV) begin m_step = 1; m_age = 0; end
        end
      end
      default: ;
    endcase
    m_cnt += int'(m_step);
    old_pl = m_pl;
    qp.push_back(ps2);
    if (qp.size() > DB) qp.delete(0);
    if (settled(qp, m_pl)) m_pl = !m_pl;
    m_pl_prev = old_pl;
    qr.push_back(rs2);
    if (qr.size() > DB) qr.delete(0);
    if (settled(qr, m_rl)) m_rl = !m_rl;
    ps2 = ps1; ps1 = pushButton;
    rs2 = rs1; rs1 = runMode;
  endtask

  task automatic check_all();
    chk("cpuStep", 32'(step_a), 32'(m_step));
    chk("ctrlState", 32'(state_a), 32'(mode_code(m_mode)));
    chk("stepCount16", 32'(cnt_a), 32'(m_cnt & 16'hFFFF));
    chk("stepCount4", 32'(cnt_b), 32'(m_cnt & 4'hF));
    chk("no_back_to_back", 32'(step_a && prev_step), 32'(0));
    prev_step = step_a;
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    tick_no++;
    if (step_a) begin
      if (steps_seen == 0) first_step = tick_no;
      steps_seen++;
    end
    check_all();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic chk_zero(string tag);
    chk({tag, "_step"}, 32'(step_a), 32'(0));
    chk({tag, "_state"}, 32'(state_a), 32'(0));
    chk({tag, "_cnt"}, 32'(cnt_a), 32'(0));
  endtask

  // Asynchronous assert between edges, outputs checked before next edge
  task automatic do_reset();
    #2;
    reset = 1'b0;
    model_clear();
    #1;
    chk_zero("async_reset");
    prev_step = 1'b0;
    run(3);
    reset = 1'b1;
  endtask

  task automatic wait_state(string tag, input logic [1:0] st);
    bit hit = 0;
    for (int i = 0; i < 20 && !hit; i++) begin
      tick();
      if (state_a == st) hit = 1;
    end
    chk(tag, 32'(hit), 32'(1));
  endtask

  initial begin
    int e;
    bit wrapped;
    model_clear();
    #1;
    chk_zero("reset_state");
    @(negedge clk);
    run(3);
    reset = 1'b1;
    run(4);

    // single step
    steps_seen = 0; first_step = -1;
    e = tick_no;
    pushButton = 1'b1;
    run(20);
    chk("single_count", 32'(steps_seen), 32'(1));
    chk("single_lat_lo", 32'(first_step - e >= 7), 32'(1));
    chk("single_lat_hi", 32'(first_step - e <= 9), 32'(1));
    chk("single_cnt", 32'(cnt_a), 32'(1));
    chk("single_state", 32'(state_a), 32'(0));
    pushButton = 1'b0;
    run(20);

    // bounce
    steps_seen = 0;
    for (int i = 0; i < 10; i++) begin
      pushButton = ~pushButton;
      run(2);
    end
    chk("bounce_quiet", 32'(steps_seen), 32'(0));
    e = tick_no;
    pushButton = 1'b1;
    run(20);
    chk("bounce_count", 32'(steps_seen), 32'(1));
    chk("bounce_lat", 32'(first_step - e), 32'(DB + 3));
    pushButton = 1'b0;
    run(20);

    // free run
    runMode = 1'b1;
    run(10);
    pushButton = 1'b1;
    wait_state("run_enter", 2'b01);
    pushButton = 1'b0;
    e = tick_no;
    steps_seen = 0; first_step = -1;
    run(40);
    chk("run_first", 32'(first_step - e), 32'(DIV));
    chk("run_count", 32'(steps_seen), 32'(5));
    pushButton = 1'b1;
    wait_state("run_exit", 2'b00);
    steps_seen = 0;
    run(30);
    chk("run_exit_quiet", 32'(steps_seen), 32'(0));
    pushButton = 1'b0;
    run(20);

    // halt on the rate-tick cycle
    pushButton = 1'b1;
    wait_state("halt_enter_run", 2'b01);
    pushButton = 1'b0;
    run(7);
    haltReq = 1'b1;
    tick();
    chk("halt_nostep", 32'(step_a), 32'(0));
    chk("halt_state", 32'(state_a), 32'(2));
    haltReq = 1'b0;
    steps_seen = 0;
    runMode = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pushButton = 1'b1;
      run(15);
      pushButton = 1'b0;
      run(15);
    end
    chk("halt_quiet", 32'(steps_seen), 32'(0));
    chk("halt_sticky", 32'(state_a), 32'(2));
    do_reset();
    run(10);

    // button held through reset release
    pushButton = 1'b1;
    run(3);
    do_reset();
    steps_seen = 0;
    run(15);
    chk("held_press", 32'(steps_seen), 32'(1));
    pushButton = 1'b0;
    run(15);

    // counter wrap, then reset mid-run
    runMode = 1'b1;
    run(10);
    pushButton = 1'b1;
    wait_state("wrap_enter", 2'b01);
    pushButton = 1'b0;
    wrapped = 0;
    for (int i = 0; i < 200 && !wrapped; i++) begin
      tick();
      if (m_cnt == 16) begin
        wrapped = 1;
        chk("wrap4_zero", 32'(cnt_b), 32'(0));
        chk("wrap16_cnt", 32'(cnt_a), 32'(16));
      end
    end
    chk("wrap_seen", 32'(wrapped), 32'(1));
    run(3);
    chk("midrun_state", 32'(state_a), 32'(1));
    do_reset();
    run(10);

    // random traffic
    for (int s = 0; s < 80; s++) begin
      int act;
      act = int'($urandom_range(0, 9));
      if (act <= 5) begin
        pushButton = 1'b1;
        run(int'($urandom_range(1, 12)));
        pushButton = 1'b0;
        run(int'($urandom_range(1, 12)));
      end else if (act <= 7) begin
        runMode = ~runMode;
        run(int'($urandom_range(1, 30)));
      end else if (act == 8) begin
        if ($urandom_range(0, 2) == 0) begin
          haltReq = 1'b1;
          tick();
          haltReq = 1'b0;
        end
        run(int'($urandom_range(1, 10)));
      end else begin
        do_reset();
        run(int'($urandom_range(1, 10)));
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/step_controller.md
STEP_CONTROLLER -- requirements
Module: step_controller

Interface
REQ-001 SHALL have parameter DB_CYCLES, default 500000, the number of consecutive stable samples (10 ms at 50 MHz) required to accept a button level.
REQ-002 SHALL have parameter RUN_DIV, default 5000000, the number of clk cycles between auto-steps in RUN (10 Hz at 50 MHz); legal range 2..2^24-1.
REQ-003 SHALL have parameter CNT_W, default 16, the width of stepCount.
REQ-004 clk  input  1  board clock; the only clock; all state updates on its rising edge.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 pushButton  input  1  raw, bouncing, asynchronous step/run button.
REQ-007 runMode  input  1  raw asynchronous slide switch: 0 = single-step, 1 = free-run.
REQ-008 haltReq  input  1  level from the processor: a halt condition is present; synchronous to clk.
REQ-009 cpuStep  output  1  registered one-cycle step enable to the processor.
REQ-010 ctrlState  output  2  current FSM state: 00 IDLE, 01 RUN, 10 HALTED.
REQ-011 stepCount  output  CNT_W  count of cpuStep pulses issued.

Function
REQ-012 pushButton and runMode SHALL each pass through a 2-flop synchronizer before use.
REQ-013 Debounce: the accepted level SHALL change only after the synchronized input has differed from it for DB_CYCLES consecutive cycles; any reversion SHALL restart the count at 0.
REQ-014 press SHALL be a one-cycle internal pulse on the 0->1 edge of the debounced pushButton; a release SHALL produce no pulse.
REQ-015 runMode SHALL be debounced identically to pushButton (same DB_CYCLES).
REQ-016 IDLE: haltReq -> HALTED; else press with runMode=0 -> one cpuStep and stay IDLE; else press with runMode=1 -> RUN.
REQ-017 RUN: rate counter SHALL be cleared to 0 on entry, increment each cycle, and on reaching RUN_DIV-1 issue one cpuStep and wrap to 0; first auto-step SHALL occur RUN_DIV cycles after entry.
REQ-018 RUN exits: haltReq -> HALTED; else press -> IDLE; else debounced runMode=0 -> IDLE; any exit SHALL suppress a coincident rate-tick step.
REQ-019 HALTED SHALL issue no cpuStep, ignore press and runMode, and be left only by reset.
REQ-020 Same-cycle priority SHALL be haltReq > press > runMode change > rate tick.
REQ-021 cpuStep SHALL be high for exactly one cycle per step decision, registered, one cycle after the deciding cycle; never high on two consecutive cycles.
REQ-022 stepCount SHALL increment in the same cycle cpuStep is high and wrap from 2^CNT_W-1 to 0.
REQ-023 Press-to-step latency in IDLE SHALL be between DB_CYCLES+3 and DB_CYCLES+5 clk cycles after a clean raw rising edge.

Reset
REQ-024 Asserting reset (low) SHALL immediately force ctrlState=IDLE, cpuStep=0, stepCount=0, rate and debounce counters=0, synchronizers and debounced levels=0, with no dependence on clk.
REQ-025 A reset mid-debounce or mid-RUN SHALL discard the partial count; a button held through reset release SHALL register as a press after a full debounce.

Structure
REQ-026 State encodings (IDLE/RUN/HALTED) and default DB_CYCLES/RUN_DIV SHALL live in shared package cpu_ctrl_pkg.
REQ-027 Synchronizer plus debouncer SHALL be a sub-module button_debounce, instantiated twice (pushButton, runMode); FSM, rate counter and stepCount stay in step_controller.

Verification (bench with DB_CYCLES=4, RUN_DIV=8)
REQ-028 Single step: runMode=0, clean press held 20 cycles -> exactly one cpuStep, 7-9 cycles after raw edge; stepCount 0->1; ctrlState stays 00.
REQ-029 Bounce: pushButton toggled every 2 cycles for 20 cycles, then held high -> exactly one cpuStep, only after the final stable edge plus debounce.
REQ-030 Run: runMode=1, press -> ctrlState=01; cpuStep every 8 cycles, first 8 cycles after entry; second press -> ctrlState=00, no further steps.
REQ-031 Halt priority: in RUN, assert haltReq in the cycle the rate counter hits 7 -> no cpuStep, ctrlState=10; later presses produce nothing until reset.
REQ-032 Wrap/reset: preload via 65535 steps (CNT_W=16) -> next step gives stepCount=0; assert reset mid-RUN asynchronously -> all outputs 0 before the next clk edge.
